// File: rtl/dcache_miss_ctrl.sv
// dcache_miss_ctrl: miss-status holding registers for the 32-entry direct-mapped dcache.
// Takes up to two load misses per cycle, merges duplicate blocks, issues BUS_LOAD
// requests to memory and drives the cache fill port when tagged data returns.
// Optional feature macro: DMEM_NEXTLINE_PF_EN adds a next-line prefetch on each new
// demand allocation; with it undefined only demand misses are tracked.
module dcache_miss_ctrl #(
  parameter int MSHR_N    = 4,
  parameter int IDX_W     = 5,
  parameter int TAG_W     = 8,
  parameter int DATA_W    = 64,
  parameter int MEM_TAG_W = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             miss_req,
  input  logic [2*IDX_W-1:0]     miss_idx,
  input  logic [2*TAG_W-1:0]     miss_tag,
  output logic [1:0]             miss_ready,
  output logic [1:0]             proc2mem_command,
  output logic [63:0]            proc2mem_addr,
  input  logic [MEM_TAG_W-1:0]   mem2proc_response,
  input  logic [MEM_TAG_W-1:0]   mem2proc_tag,
  input  logic [DATA_W-1:0]      mem2proc_data,
  output logic                   ld_en,
  output logic [IDX_W-1:0]       ld_idx,
  output logic [TAG_W-1:0]       ld_tag,
  output logic [DATA_W-1:0]      ld_data,
  output logic                   mshr_full
);

  typedef enum logic [1:0] {
    FREE       = 2'd0,
    WAIT_ISSUE = 2'd1,
    WAIT_MEM   = 2'd2
  } mshr_state_e;

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  // Isolates the lowest set bit, which is how every "lowest-numbered entry" pick is made.
  function automatic logic [MSHR_N-1:0] lowest_bit(input logic [MSHR_N-1:0] m);
    return m & (~m + MSHR_N'(1));
  endfunction

  mshr_state_e          state_q [MSHR_N];
  mshr_state_e          state_d [MSHR_N];
  logic [IDX_W-1:0]     idx_q   [MSHR_N];
  logic [IDX_W-1:0]     idx_d   [MSHR_N];
  logic [TAG_W-1:0]     tag_q   [MSHR_N];
  logic [TAG_W-1:0]     tag_d   [MSHR_N];
  logic [MEM_TAG_W-1:0] mtag_q  [MSHR_N];
  logic [MEM_TAG_W-1:0] mtag_d  [MSHR_N];
  logic                 full_d;

  logic [IDX_W-1:0]     req_idx [2];
  logic [TAG_W-1:0]     req_tag [2];

  logic [1:0]           hit;
  logic                 same_blk;
  logic                 need0;
  logic                 need1;
  logic                 ready0;
  logic                 ready1;
  logic [MSHR_N-1:0]    free_mask;
  logic [MSHR_N-1:0]    issue_mask;
  logic [MSHR_N-1:0]    fill_mask;
  logic [MSHR_N-1:0]    issue_oh;
  logic [MSHR_N-1:0]    fill_oh;
  logic [MSHR_N-1:0]    alloc0_oh;
  logic [MSHR_N-1:0]    alloc1_oh;
  logic [MSHR_N-1:0]    alloc_pf_oh;
  logic [MSHR_N-1:0]    rem_after0;
  logic [MSHR_N-1:0]    rem_after1;
  logic [IDX_W-1:0]     pf_idx;
  logic [TAG_W-1:0]     pf_tag;

  assign req_idx[0] = miss_idx[IDX_W-1:0];
  assign req_idx[1] = miss_idx[2*IDX_W-1:IDX_W];
  assign req_tag[0] = miss_tag[TAG_W-1:0];
  assign req_tag[1] = miss_tag[2*TAG_W-1:TAG_W];

  // Classify entries and detect requests that hit an in-flight block (including one filling now).
  always_comb begin
    free_mask  = '0;
    issue_mask = '0;
    fill_mask  = '0;
    hit        = '0;
    for (int i = 0; i < MSHR_N; i++) begin
      free_mask[i]  = (state_q[i] == FREE);
      issue_mask[i] = (state_q[i] == WAIT_ISSUE);
      fill_mask[i]  = (state_q[i] == WAIT_MEM) && (mem2proc_tag != '0) &&
                      (mtag_q[i] == mem2proc_tag);
      for (int p = 0; p < 2; p++) begin
        if ((state_q[i] != FREE) && (idx_q[i] == req_idx[p]) && (tag_q[i] == req_tag[p])) begin
          hit[p] = 1'b1;
        end
      end
    end
  end

  assign issue_oh = lowest_bit(issue_mask);
  assign fill_oh  = lowest_bit(fill_mask);

  // Demand allocation: port 0 takes the lowest free entry, port 1 the next one; a port-1
  // request for the same block as port 0 rides on port 0's outcome.
  always_comb begin
    same_blk   = miss_req[0] && (req_idx[0] == req_idx[1]) && (req_tag[0] == req_tag[1]);
    need0      = miss_req[0] && !hit[0];
    need1      = miss_req[1] && !hit[1] && !same_blk;
    alloc0_oh  = need0 ? lowest_bit(free_mask) : '0;
    rem_after0 = free_mask & ~alloc0_oh;
    alloc1_oh  = need1 ? lowest_bit(rem_after0) : '0;
    rem_after1 = rem_after0 & ~alloc1_oh;
    ready0     = !need0 || (|free_mask);
    ready1     = same_blk ? ready0 : (!need1 || (|rem_after0));
  end

`ifdef DMEM_NEXTLINE_PF_EN
  logic             pf_src_valid;
  logic             pf_wrap;
  logic             pf_dup;
  logic [IDX_W-1:0] pf_src_idx;
  logic [TAG_W-1:0] pf_src_tag;

  // Next-line prefetch for the highest-priority new demand allocation, skipped when the
  // block is already tracked, is being allocated now, or would run past the top tag.
  always_comb begin
    pf_src_valid = (|alloc0_oh) || (|alloc1_oh);
    pf_src_idx   = (|alloc0_oh) ? req_idx[0] : req_idx[1];
    pf_src_tag   = (|alloc0_oh) ? req_tag[0] : req_tag[1];
    pf_wrap      = &pf_src_idx;
    pf_idx       = pf_src_idx + IDX_W'(1);
    pf_tag       = pf_wrap ? (pf_src_tag + TAG_W'(1)) : pf_src_tag;
    pf_dup       = 1'b0;
    for (int i = 0; i < MSHR_N; i++) begin
      if (!free_mask[i] && (idx_q[i] == pf_idx) && (tag_q[i] == pf_tag)) begin
        pf_dup = 1'b1;
      end
    end
    if ((|alloc0_oh) && (req_idx[0] == pf_idx) && (req_tag[0] == pf_tag)) begin
      pf_dup = 1'b1;
    end
    if ((|alloc1_oh) && (req_idx[1] == pf_idx) && (req_tag[1] == pf_tag)) begin
      pf_dup = 1'b1;
    end
    alloc_pf_oh = '0;
    if (pf_src_valid && !(pf_wrap && (&pf_src_tag)) && !pf_dup) begin
      alloc_pf_oh = lowest_bit(rem_after1);
    end
  end
`else
  assign alloc_pf_oh = '0;
  assign pf_idx      = '0;
  assign pf_tag      = '0;
`endif

  // Per-entry next state: issue acceptance, fill release and new allocations touch
  // disjoint entries, so their order here does not matter.
  always_comb begin
    full_d = 1'b1;
    for (int i = 0; i < MSHR_N; i++) begin
      state_d[i] = state_q[i];
      idx_d[i]   = idx_q[i];
      tag_d[i]   = tag_q[i];
      mtag_d[i]  = mtag_q[i];
      if (issue_oh[i] && (mem2proc_response != '0)) begin
        state_d[i] = WAIT_MEM;
        mtag_d[i]  = mem2proc_response;
      end
      if (fill_oh[i]) begin
        state_d[i] = FREE;
      end
      if (alloc0_oh[i]) begin
        state_d[i] = WAIT_ISSUE;
        idx_d[i]   = req_idx[0];
        tag_d[i]   = req_tag[0];
      end
      if (alloc1_oh[i]) begin
        state_d[i] = WAIT_ISSUE;
        idx_d[i]   = req_idx[1];
        tag_d[i]   = req_tag[1];
      end
      if (alloc_pf_oh[i]) begin
        state_d[i] = WAIT_ISSUE;
        idx_d[i]   = pf_idx;
        tag_d[i]   = pf_tag;
      end
      if (state_d[i] == FREE) begin
        full_d = 1'b0;
      end
    end
  end

  // Bus request, fill port and ready outputs; all held quiet while reset is asserted.
  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    ld_en            = 1'b0;
    ld_idx           = '0;
    ld_tag           = '0;
    ld_data          = '0;
    miss_ready       = reset ? 2'b00 : {ready1, ready0};
    for (int i = 0; i < MSHR_N; i++) begin
      if (issue_oh[i] && !reset) begin
        proc2mem_command = BUS_LOAD;
        proc2mem_addr    = 64'({tag_q[i], idx_q[i], 3'b000});
      end
      if (fill_oh[i] && !reset) begin
        ld_en   = 1'b1;
        ld_idx  = idx_q[i];
        ld_tag  = tag_q[i];
        ld_data = mem2proc_data;
      end
    end
  end

  // Entry registers and the registered full flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MSHR_N; i++) begin
        state_q[i] <= FREE;
        idx_q[i]   <= '0;
        tag_q[i]   <= '0;
        mtag_q[i]  <= '0;
      end
      mshr_full <= 1'b0;
    end else begin
      for (int i = 0; i < MSHR_N; i++) begin
        state_q[i] <= state_d[i];
        idx_q[i]   <= idx_d[i];
        tag_q[i]   <= tag_d[i];
        mtag_q[i]  <= mtag_d[i];
      end
      mshr_full <= full_d;
    end
  end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Self-checking bench for dcache_miss_ctrl: a block-number model predicts every output
// each cycle, and directed sequences pin key values with hand-computed literals.
module tb_dcache_miss_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  miss_req = '0;
  logic [9:0]  miss_idx = '0;
  logic [15:0] miss_tag = '0;
  logic [3:0]  mem2proc_response = '0;
  logic [3:0]  mem2proc_tag = '0;
  logic [63:0] mem2proc_data = '0;
  logic [1:0]  miss_ready;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic        ld_en;
  logic [4:0]  ld_idx;
  logic [7:0]  ld_tag;
  logic [63:0] ld_data;
  logic        mshr_full;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  dcache_miss_ctrl dut (
    .clock(clock), .reset(reset),
    .miss_req(miss_req), .miss_idx(miss_idx), .miss_tag(miss_tag),
    .miss_ready(miss_ready),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .mem2proc_response(mem2proc_response), .mem2proc_tag(mem2proc_tag),
    .mem2proc_data(mem2proc_data),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_tag(ld_tag), .ld_data(ld_data),
    .mshr_full(mshr_full)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: each entry tracks a block number (tag*32+idx), whether the bus accepted it,
  // and the memory tag it was accepted with.
  bit mb [4];
  bit ms [4];
  int mblk [4];
  int mmt [4];
  bit pl_reset;
  int pl_fill, pl_issue, pl_a0, pl_a1, pl_pf, pl_b0, pl_b1, pl_pfb, pl_resp;

  function automatic bit inflight(input int b);
    for (int i = 0; i < 4; i++) if (mb[i] && mblk[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  // Predict this cycle's outputs from the model and compare.
  always @(negedge clock) begin
    int b0, b1, nfree, src;
    int fl[$];
    logic [1:0] e_ready;
    bit e_load, e_ld;
    if (chk_en) begin
      e_ready = 2'b11; e_load = 1'b0; e_ld = 1'b0;
      pl_reset = reset; pl_fill = -1; pl_issue = -1;
      pl_a0 = -1; pl_a1 = -1; pl_pf = -1; pl_pfb = 0;
      b0 = int'(miss_tag[7:0]) * 32 + int'(miss_idx[4:0]);
      b1 = int'(miss_tag[15:8]) * 32 + int'(miss_idx[9:5]);
      pl_b0 = b0; pl_b1 = b1; pl_resp = int'(mem2proc_response);
      nfree = 0; fl.delete();
      for (int i = 0; i < 4; i++) if (!mb[i]) begin nfree++; fl.push_back(i); end
      if (reset) e_ready = 2'b00;
      else begin
        for (int i = 0; i < 4; i++)
          if (pl_fill < 0 && mb[i] && ms[i] && mem2proc_tag != 0 && mmt[i] == int'(mem2proc_tag)) pl_fill = i;
        for (int i = 0; i < 4; i++)
          if (pl_issue < 0 && mb[i] && !ms[i]) pl_issue = i;
        e_ld = (pl_fill >= 0);
        e_load = (pl_issue >= 0);
        if (miss_req[0] && !inflight(b0)) begin
          if (fl.size() > 0) pl_a0 = fl.pop_front(); else e_ready[0] = 1'b0;
        end
        if (miss_req[1]) begin
          if (miss_req[0] && b1 == b0) e_ready[1] = e_ready[0];
          else if (!inflight(b1)) begin
            if (fl.size() > 0) pl_a1 = fl.pop_front(); else e_ready[1] = 1'b0;
          end
        end
`ifdef DMEM_NEXTLINE_PF_EN
        src = (pl_a0 >= 0) ? b0 : ((pl_a1 >= 0) ? b1 : -1);
        if (src >= 0 && src < 8191 && fl.size() > 0 && !inflight(src + 1) &&
            !(pl_a0 >= 0 && b0 == src + 1) && !(pl_a1 >= 0 && b1 == src + 1)) begin
          pl_pf = fl.pop_front();
          pl_pfb = src + 1;
        end
`else
        src = -1;
`endif
      end
      checkOutput("miss_ready", 64'(miss_ready), 64'(e_ready));
      checkOutput("command", 64'(proc2mem_command), e_load ? 64'd1 : 64'd0);
      if (e_load) checkOutput("addr", proc2mem_addr, 64'(mblk[pl_issue]) << 3);
      checkOutput("ld_en", 64'(ld_en), 64'(e_ld));
      if (e_ld) begin
        checkOutput("ld_idx", 64'(ld_idx), 64'(mblk[pl_fill] % 32));
        checkOutput("ld_tag", 64'(ld_tag), 64'(mblk[pl_fill] / 32));
        checkOutput("ld_data", ld_data, mem2proc_data);
      end
      checkOutput("mshr_full", 64'(mshr_full), 64'(nfree == 0));
    end
  end

  // Advance the model with the decisions taken for the cycle that just ended.
  always @(posedge clock) begin
    if (chk_en) begin
      if (pl_reset) begin
        for (int i = 0; i < 4; i++) begin mb[i] <= 1'b0; ms[i] <= 1'b0; end
      end else begin
        if (pl_issue >= 0 && pl_resp != 0) begin ms[pl_issue] <= 1'b1; mmt[pl_issue] <= pl_resp; end
        if (pl_fill >= 0) mb[pl_fill] <= 1'b0;
        if (pl_a0 >= 0) begin mb[pl_a0] <= 1'b1; ms[pl_a0] <= 1'b0; mblk[pl_a0] <= pl_b0; end
        if (pl_a1 >= 0) begin mb[pl_a1] <= 1'b1; ms[pl_a1] <= 1'b0; mblk[pl_a1] <= pl_b1; end
        if (pl_pf >= 0) begin mb[pl_pf] <= 1'b1; ms[pl_pf] <= 1'b0; mblk[pl_pf] <= pl_pfb; end
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] req, input logic [4:0] i0, input logic [7:0] t0,
                               input logic [4:0] i1, input logic [7:0] t1, input logic [3:0] resp,
                               input logic [3:0] rtag, input logic [63:0] data);
    @(posedge clock);
    #1;
    miss_req = req;
    miss_idx = {i1, i0};
    miss_tag = {t1, t0};
    mem2proc_response = resp;
    mem2proc_tag = rtag;
    mem2proc_data = data;
  endtask

  task automatic idle();
    applyStimulus(2'b00, 5'd0, 8'd0, 5'd0, 8'd0, 4'd0, 4'd0, 64'd0);
  endtask

  task automatic doReset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    miss_req = '0; mem2proc_response = '0; mem2proc_tag = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    $display("[TB] starting dcache_miss_ctrl bench");
    @(posedge clock);
    #1;
    chk_en = 1'b1;
    doReset();
    @(negedge clock);
    checkOutput("reset ready", 64'(miss_ready), 64'h3);
    checkOutput("reset full", 64'(mshr_full), 64'h0);
    checkOutput("reset cmd", 64'(proc2mem_command), 64'h0);
    checkOutput("reset ld_en", 64'(ld_en), 64'h0);

    // Single miss: {tag 12h, idx 3, 3'b0} = 0x1218.
    applyStimulus(2'b01, 5'd3, 8'h12, 5'd0, 8'd0, 4'd0, 4'd0, 64'd0);
    @(negedge clock);
    checkOutput("t1 ready", 64'(miss_ready), 64'h3);
    applyStimulus(2'b00, 5'd0, 8'd0, 5'd0, 8'd0, 4'd1, 4'd0, 64'd0);
    @(negedge clock);
    checkOutput("t1 cmd", 64'(proc2mem_command), 64'h1);
    checkOutput("t1 addr", proc2mem_addr, 64'h1218);
    applyStimulus(2'b00, 5'd0, 8'd0, 5'd0, 8'd0, 4'd0, 4'd1, 64'hDEADBEEF_CAFEF00D);
    @(negedge clock);
    checkOutput("t1 ld_en", 64'(ld_en), 64'h1);
    checkOutput("t1 ld_idx", 64'(ld_idx), 64'h3);
    checkOutput("t1 ld_tag", 64'(ld_tag), 64'h12);
    checkOutput("t1 ld_data", ld_data, 64'hDEADBEEF_CAFEF00D);
    idle();
    @(negedge clock);
    checkOutput("t1 ld_en off", 64'(ld_en), 64'h0);

    // Same block on both ports; then a request merging into the filling block.
    doReset();
    applyStimulus(2'b11, 5'd5, 8'd7, 5'd5, 8'd7, 4'd0, 4'd0, 64'd0);
    @(negedge clock);
    checkOutput("t2 ready", 64'(miss_ready), 64'h3);
    applyStimulus(2'b00, 5'd0, 8'd0, 5'd0, 8'd0, 4'd2, 4'd0, 64'd0);
    @(negedge clock);
    checkOutput("t2 addr", proc2mem_addr, 64'h728);
    idle();
    @(negedge clock);
`ifndef DMEM_NEXTLINE_PF_EN
    checkOutput("t2 single load", 64'(proc2mem_command), 64'h0);
`endif
    applyStimulus(2'b01, 5'd5, 8'd7, 5'd0, 8'd0, 4'd0, 4'd2, 64'h1111_2222_3333_4444);
    @(negedge clock);
    checkOutput("t2 fill ready", 64'(miss_ready), 64'h3);
    checkOutput("t2 ld_en", 64'(ld_en), 64'h1);
    checkOutput("t2 ld_idx", 64'(ld_idx), 64'h5);
    idle();
    @(negedge clock);
`ifndef DMEM_NEXTLINE_PF_EN
    checkOutput("t2 merge no alloc", 64'(proc2mem_command), 64'h0);
`endif

    // Fill all entries, get rejected, then accepted the cycle after a fill.
    doReset();
    applyStimulus(2'b11, 5'd1, 8'd1, 5'd2, 8'd1, 4'd0, 4'd0, 64'd0);
    applyStimulus(2'b11, 5'd3, 8'd1, 5'd4, 8'd1, 4'd0, 4'd0, 64'd0);
    @(negedge clock);
    checkOutput("t3 ready 4th", 64'(miss_ready), 64'h3);
    applyStimulus(2'b01, 5'd6, 8'd1, 5'd0, 8'd0, 4'd3, 4'd0, 64'd0);
    @(negedge clock);
    checkOutput("t3 rejected", 64'(miss_ready), 64'h2);
    checkOutput("t3 full", 64'(mshr_full), 64'h1);
    applyStimulus(2'b01, 5'd6, 8'd1, 5'd0, 8'd0, 4'd0, 4'd3, 64'h55);
    @(negedge clock);
    checkOutput("t3 fill", 64'(ld_en), 64'h1);
    checkOutput("t3 fill idx", 64'(ld_idx), 64'h1);
    checkOutput("t3 still rejected", 64'(miss_ready), 64'h2);
    applyStimulus(2'b01, 5'd6, 8'd1, 5'd0, 8'd0, 4'd0, 4'd0, 64'd0);
    @(negedge clock);
    checkOutput("t3 accepted", 64'(miss_ready), 64'h3);
    checkOutput("t3 not full", 64'(mshr_full), 64'h0);

    // Bus holds off for three cycles; {tag 20h, idx 9, 3'b0} = 0x2048.
    doReset();
    applyStimulus(2'b01, 5'd9, 8'h20, 5'd0, 8'd0, 4'd0, 4'd0, 64'd0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(2'b00, 5'd0, 8'd0, 5'd0, 8'd0, (c == 3) ? 4'd2 : 4'd0, 4'd0, 64'd0);
      @(negedge clock);
      checkOutput("t4 held cmd", 64'(proc2mem_command), 64'h1);
      checkOutput("t4 held addr", proc2mem_addr, 64'h2048);
    end
    applyStimulus(2'b00, 5'd0, 8'd0, 5'd0, 8'd0, 4'd0, 4'd5, 64'h77);
    @(negedge clock);
    checkOutput("t4 unmatched", 64'(ld_en), 64'h0);
`ifndef DMEM_NEXTLINE_PF_EN
    checkOutput("t4 issued", 64'(proc2mem_command), 64'h0);
`endif
    applyStimulus(2'b00, 5'd0, 8'd0, 5'd0, 8'd0, 4'd0, 4'd2, 64'h88);
    @(negedge clock);
    checkOutput("t4 fill", 64'(ld_en), 64'h1);
    checkOutput("t4 fill tag", 64'(ld_tag), 64'h20);
    checkOutput("t4 fill data", ld_data, 64'h88);

    // Reset with two entries waiting on memory; late responses must be dropped.
    doReset();
    applyStimulus(2'b11, 5'd10, 8'd3, 5'd11, 8'd3, 4'd0, 4'd0, 64'd0);
    applyStimulus(2'b00, 5'd0, 8'd0, 5'd0, 8'd0, 4'd4, 4'd0, 64'd0);
    @(negedge clock);
    checkOutput("t5 addr0", proc2mem_addr, 64'h350);
    applyStimulus(2'b00, 5'd0, 8'd0, 5'd0, 8'd0, 4'd6, 4'd0, 64'd0);
    @(negedge clock);
    checkOutput("t5 addr1", proc2mem_addr, 64'h358);
    @(posedge clock);
    #1;
    reset = 1'b1;
    mem2proc_response = '0;
    @(negedge clock);
    checkOutput("t5 in reset ready", 64'(miss_ready), 64'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    mem2proc_tag = 4'd4;
    mem2proc_data = 64'h99;
    @(negedge clock);
    checkOutput("t5 drop tag4", 64'(ld_en), 64'h0);
    checkOutput("t5 full", 64'(mshr_full), 64'h0);
    applyStimulus(2'b00, 5'd0, 8'd0, 5'd0, 8'd0, 4'd0, 4'd6, 64'h9A);
    @(negedge clock);
    checkOutput("t5 drop tag6", 64'(ld_en), 64'h0);
    checkOutput("t5 no cmd", 64'(proc2mem_command), 64'h0);

    // Next-line prefetch across an index wrap, and none at the top tag.
    doReset();
    applyStimulus(2'b01, 5'd31, 8'd4, 5'd0, 8'd0, 4'd0, 4'd0, 64'd0);
    applyStimulus(2'b00, 5'd0, 8'd0, 5'd0, 8'd0, 4'd1, 4'd0, 64'd0);
    @(negedge clock);
    checkOutput("t6 demand addr", proc2mem_addr, 64'h4F8);
    applyStimulus(2'b00, 5'd0, 8'd0, 5'd0, 8'd0, 4'd2, 4'd0, 64'd0);
    @(negedge clock);
`ifdef DMEM_NEXTLINE_PF_EN
    checkOutput("t6 pf cmd", 64'(proc2mem_command), 64'h1);
    checkOutput("t6 pf addr", proc2mem_addr, 64'h500);
    doReset();
    applyStimulus(2'b01, 5'd31, 8'hFF, 5'd0, 8'd0, 4'd0, 4'd0, 64'd0);
    applyStimulus(2'b00, 5'd0, 8'd0, 5'd0, 8'd0, 4'd1, 4'd0, 64'd0);
    @(negedge clock);
    checkOutput("t6 top addr", proc2mem_addr, 64'hFFF8);
    idle();
    @(negedge clock);
    checkOutput("t6 no pf", 64'(proc2mem_command), 64'h0);
`else
    checkOutput("t6 no pf", 64'(proc2mem_command), 64'h0);
`endif

    // Mixed traffic with frequent merges, rejections and out-of-order tag returns.
    doReset();
    for (int k = 0; k < 80; k++) begin
      if (k == 40) doReset();
      applyStimulus(2'(k % 4), 5'((k * 3) % 8), 8'(k % 2), 5'((k * 5) % 8), 8'((k / 2) % 2),
                    (k % 3 == 2) ? 4'd0 : 4'((k % 15) + 1),
                    (k % 5 == 0) ? 4'd0 : 4'(((k + 12) % 15) + 1),
                    {32'(k), 32'hA5A5_0000});
    end
    repeat (3) idle();
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
